// File: rtl/alsaqr_cdc_pkg.sv
// Shared types and helpers for the AlSaqr gray-pointer AXI-Lite crossing:
// default request/response structs, per-channel entry widths and gray conversion.
package alsaqr_cdc_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 64;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   aw_addr;
        logic [2:0]                  aw_prot;
        logic                        aw_valid;
        logic [DEF_DATA_WIDTH-1:0]   w_data;
        logic [DEF_DATA_WIDTH/8-1:0] w_strb;
        logic                        w_valid;
        logic                        b_ready;
        logic [DEF_ADDR_WIDTH-1:0]   ar_addr;
        logic [2:0]                  ar_prot;
        logic                        ar_valid;
        logic                        r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic                      aw_ready;
        logic                      w_ready;
        logic [1:0]                b_resp;
        logic                      b_valid;
        logic                      ar_ready;
        logic [DEF_DATA_WIDTH-1:0] r_data;
        logic [1:0]                r_resp;
        logic                      r_valid;
    } axi_lite_resp_t;

    function automatic int aw_width(input int addr_width);
        return addr_width + 32'sd3;
    endfunction

    function automatic int w_width(input int data_width);
        return data_width + data_width / 32'sd8;
    endfunction

    function automatic int b_width();
        return 32'sd2;
    endfunction

    function automatic int r_width(input int data_width);
        return data_width + 32'sd2;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/alsaqr_gray_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded FIFO pointer arriving from the
// other clock domain; clears synchronously on rst.
module alsaqr_gray_ptr_sync #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Shift the remote pointer through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign sync_out = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/axi_lite_cdc_dst_alsaqr.sv
// Destination end of the AlSaqr gray-pointer AXI-Lite crossing: drains the
// AW/W/AR async FIFOs onto a local master port and fills the B/R return FIFOs.
module axi_lite_cdc_dst_alsaqr
    import alsaqr_cdc_pkg::*;
#(
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter int  AXI_DATA_WIDTH = 64,
    parameter int  LOG_DEPTH      = 1,
    parameter int  SYNC_STAGES    = 2,
    parameter type req_t          = axi_lite_req_t,
    parameter type resp_t         = axi_lite_resp_t,
    localparam int D              = 2 ** LOG_DEPTH,
    localparam int P              = LOG_DEPTH + 1,
    localparam int AW_W           = aw_width(AXI_ADDR_WIDTH),
    localparam int W_W            = w_width(AXI_DATA_WIDTH),
    localparam int B_W            = b_width(),
    localparam int R_W            = r_width(AXI_DATA_WIDTH)
) (
    input  logic            dst_clk_i,
    input  logic            dst_rst_i,
    output req_t            dst_req_o,
    input  resp_t           dst_resp_i,
    input  logic [D*AW_W-1:0] aw_data_i,
    input  logic [P-1:0]    aw_wptr_i,
    output logic [P-1:0]    aw_rptr_o,
    input  logic [D*W_W-1:0] w_data_i,
    input  logic [P-1:0]    w_wptr_i,
    output logic [P-1:0]    w_rptr_o,
    input  logic [D*AW_W-1:0] ar_data_i,
    input  logic [P-1:0]    ar_wptr_i,
    output logic [P-1:0]    ar_rptr_o,
    output logic [D*B_W-1:0] b_data_o,
    output logic [P-1:0]    b_wptr_o,
    input  logic [P-1:0]    b_rptr_i,
    output logic [D*R_W-1:0] r_data_o,
    output logic [P-1:0]    r_wptr_o,
    input  logic [P-1:0]    r_rptr_i
);

    // Writer is full when the pointers differ only in their two top gray bits.
    localparam logic [P-1:0] FULL_MASK = P'(2'b11) << (P - 2);

    logic [P-1:0]         rd_wptr_remote [3];
    logic [P-1:0]         rd_rptr_gray   [3];
    logic [LOG_DEPTH-1:0] rd_idx         [3];
    logic [2:0]           rd_valid;
    logic [2:0]           rd_ready;

    logic [P-1:0]         wr_rptr_remote [2];
    logic [P-1:0]         wr_wptr_gray   [2];
    logic [LOG_DEPTH-1:0] wr_idx         [2];
    logic [1:0]           wr_valid;
    logic [1:0]           wr_ready;
    logic [1:0]           wr_fire;

    logic [AW_W-1:0] aw_entry_s;
    logic [W_W-1:0]  w_entry_s;
    logic [AW_W-1:0] ar_entry_s;
    logic [B_W-1:0]  b_mem_r [D];
    logic [R_W-1:0]  r_mem_r [D];

    assign rd_wptr_remote[0] = aw_wptr_i;
    assign rd_wptr_remote[1] = w_wptr_i;
    assign rd_wptr_remote[2] = ar_wptr_i;
    assign rd_ready          = {dst_resp_i.ar_ready, dst_resp_i.w_ready, dst_resp_i.aw_ready};

    for (genvar c = 0; c < 3; c++) begin : g_rd
        logic [P-1:0] wptr_sync_s;
        logic [P-1:0] rptr_bin_r;
        logic [P-1:0] rptr_gray_r;
        logic [P-1:0] rptr_bin_next_s;

        alsaqr_gray_ptr_sync #(
            .WIDTH       (P),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (dst_clk_i),
            .rst      (dst_rst_i),
            .async_in (rd_wptr_remote[c]),
            .sync_out (wptr_sync_s)
        );

        assign rptr_bin_next_s = rptr_bin_r + P'(1'b1);
        assign rd_valid[c]     = (wptr_sync_s != rptr_gray_r) && !dst_rst_i;
        assign rd_idx[c]       = rptr_bin_r[LOG_DEPTH-1:0];
        assign rd_rptr_gray[c] = rptr_gray_r;

        // Pop one entry per master handshake; the gray copy moves on the same edge.
        always_ff @(posedge dst_clk_i) begin
            if (dst_rst_i) begin
                rptr_bin_r  <= '0;
                rptr_gray_r <= '0;
            end else if (rd_valid[c] && rd_ready[c]) begin
                rptr_bin_r  <= rptr_bin_next_s;
                rptr_gray_r <= P'(bin2gray(32'(rptr_bin_next_s)));
            end
        end
    end

    assign aw_rptr_o = rd_rptr_gray[0];
    assign w_rptr_o  = rd_rptr_gray[1];
    assign ar_rptr_o = rd_rptr_gray[2];

    assign aw_entry_s = aw_data_i[int'(rd_idx[0]) * AW_W +: AW_W];
    assign w_entry_s  = w_data_i[int'(rd_idx[1]) * W_W +: W_W];
    assign ar_entry_s = ar_data_i[int'(rd_idx[2]) * AW_W +: AW_W];

    assign wr_rptr_remote[0] = b_rptr_i;
    assign wr_rptr_remote[1] = r_rptr_i;
    assign wr_valid          = {dst_resp_i.r_valid, dst_resp_i.b_valid};

    for (genvar c = 0; c < 2; c++) begin : g_wr
        logic [P-1:0] rptr_sync_s;
        logic [P-1:0] wptr_bin_r;
        logic [P-1:0] wptr_gray_r;
        logic [P-1:0] wptr_bin_next_s;
        logic         full_s;

        alsaqr_gray_ptr_sync #(
            .WIDTH       (P),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (dst_clk_i),
            .rst      (dst_rst_i),
            .async_in (wr_rptr_remote[c]),
            .sync_out (rptr_sync_s)
        );

        assign wptr_bin_next_s = wptr_bin_r + P'(1'b1);
        assign full_s          = (wptr_gray_r == (rptr_sync_s ^ FULL_MASK));
        assign wr_ready[c]     = !full_s && !dst_rst_i;
        assign wr_fire[c]      = wr_valid[c] && wr_ready[c];
        assign wr_idx[c]       = wptr_bin_r[LOG_DEPTH-1:0];
        assign wr_wptr_gray[c] = wptr_gray_r;

        // Publish a new entry to the source once the slave response is captured.
        always_ff @(posedge dst_clk_i) begin
            if (dst_rst_i) begin
                wptr_bin_r  <= '0;
                wptr_gray_r <= '0;
            end else if (wr_fire[c]) begin
                wptr_bin_r  <= wptr_bin_next_s;
                wptr_gray_r <= P'(bin2gray(32'(wptr_bin_next_s)));
            end
        end
    end

    assign b_wptr_o = wr_wptr_gray[0];
    assign r_wptr_o = wr_wptr_gray[1];

    // Store the slave response in the slot named by the write pointer, on the same edge it advances.
    always_ff @(posedge dst_clk_i) begin
        if (dst_rst_i) begin
            for (int i = 0; i < D; i++) begin
                b_mem_r[i] <= '0;
                r_mem_r[i] <= '0;
            end
        end else begin
            if (wr_fire[0]) begin
                b_mem_r[wr_idx[0]] <= dst_resp_i.b_resp;
            end
            if (wr_fire[1]) begin
                r_mem_r[wr_idx[1]] <= {dst_resp_i.r_data, dst_resp_i.r_resp};
            end
        end
    end

    for (genvar i = 0; i < D; i++) begin : g_pack
        assign b_data_o[i*B_W +: B_W] = b_mem_r[i];
        assign r_data_o[i*R_W +: R_W] = r_mem_r[i];
    end

    // Assemble the master request from the FIFO heads and return-path readiness.
    always_comb begin
        dst_req_o          = '0;
        dst_req_o.aw_addr  = aw_entry_s[AW_W-1:3];
        dst_req_o.aw_prot  = aw_entry_s[2:0];
        dst_req_o.aw_valid = rd_valid[0];
        dst_req_o.w_data   = w_entry_s[W_W-1:AXI_DATA_WIDTH/8];
        dst_req_o.w_strb   = w_entry_s[AXI_DATA_WIDTH/8-1:0];
        dst_req_o.w_valid  = rd_valid[1];
        dst_req_o.ar_addr  = ar_entry_s[AW_W-1:3];
        dst_req_o.ar_prot  = ar_entry_s[2:0];
        dst_req_o.ar_valid = rd_valid[2];
        dst_req_o.b_ready  = wr_ready[0];
        dst_req_o.r_ready  = wr_ready[1];
    end

endmodule

// File: doc/axi_lite_cdc_dst_alsaqr.md
Name: axi_lite_cdc_dst_alsaqr

Overview:
- Destination (clock-domain-receiving) end of the AlSaqr gray-coded asynchronous AXI-Lite crossing.
- Consumes the AW/W/AR async FIFO data arrays and write pointers from the source end. Returns B/R through locally owned FIFO storage.
- Drives a synchronous AXI-Lite master port in the destination domain, toward peripheral crossbars and register files.
- Implements the destination-side FIFO halves natively: pointer synchronizers, gray counters and storage. It is not a wrapper.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- AXI_DATA_WIDTH, 64, AXI-Lite data width (multiple of 8).
- LOG_DEPTH, 1, each FIFO holds D = 2**LOG_DEPTH entries. Pointers are P = LOG_DEPTH+1 bits.
- SYNC_STAGES, 2, flops per pointer synchronizer (at least 2).
- req_t, logic, AXI-Lite request struct type.
- resp_t, logic, AXI-Lite response struct type.

Ports:
- dst_clk_i  in  1  destination clock.
- dst_rst_i  in  1  reset, synchronous, active-high.
- dst_req_o  out  req_t  AXI-Lite master request (aw/w/ar payload+valid, b_ready, r_ready).
- dst_resp_i  in  resp_t  AXI-Lite master response.
- aw_data_i  in  D*(ADDR+3)  async AW entries (addr, prot).
- aw_wptr_i  in  P  source AW write pointer, gray.
- aw_rptr_o  out  P  AW read pointer, gray.
- w_data_i  in  D*(DATA+DATA/8)  async W entries (data, strb).
- w_wptr_i  in  P  gray.
- w_rptr_o  out  P  gray.
- ar_data_i  in  D*(ADDR+3)  async AR entries.
- ar_wptr_i  in  P  gray.
- ar_rptr_o  out  P  gray.
- b_data_o  out  D*2  B entries (resp).
- b_wptr_o  out  P  gray.
- b_rptr_i  in  P  source B read pointer, gray.
- r_data_o  out  D*(DATA+2)  R entries (data, resp).
- r_wptr_o  out  P  gray.
- r_rptr_i  in  P  gray.

Behaviour:
- Reset: every register is forced to 0 while dst_rst_i is high at a dst_clk_i edge.
  - Pointers, synchronizer flops and B/R storage are 0.
  - All *_rptr_o, *_wptr_o, b_data_o and r_data_o are 0.
  - aw/w/ar valid are 0. b_ready and r_ready are held 0 during reset. Payloads are don't-care.
- Gray pointers: each local pointer is a P-bit binary counter that wraps from 2**P-1 to 0. The exported pointer is a register holding bin2gray of the counter.
- Reader halves (AW, W, AR):
  - The remote wptr passes through SYNC_STAGES flops.
  - empty = (synced wptr == local gray rptr).
  - valid = !empty. Payload = entry[rptr_bin[LOG_DEPTH-1:0]], combinational from the data input.
  - On valid && ready the rptr increments and the gray value is registered the same edge.
  - Payload is held stable while valid && !ready (AXI rule).
- Writer halves (B, R):
  - The remote rptr is synced through SYNC_STAGES flops.
  - full = (local gray wptr == synced rptr with its two MSBs inverted).
  - ready = !full && !dst_rst_i.
  - On valid && ready the payload is written into entry[wptr_bin[LOG_DEPTH-1:0]] and the wptr increments on the same edge.
  - The entry register updates no later than the pointer, so data is stable before the pointer is observable.
- Latency:
  - Source wptr change to master valid: SYNC_STAGES cycles; valid is asserted in cycle SYNC_STAGES after the sampling edge.
  - B/R handshake to wptr_o change: 1 cycle.
  - Freed entry visible as ready: SYNC_STAGES cycles after the source rptr changes.
- AW and W are independent FIFOs with no coupling between them. Channel ordering obeys AXI-Lite.
- Boundary conditions:
  - Full on a writer: ready = 0 and no overwrite.
  - Empty on a reader: valid = 0 and the pointer is frozen.
  - Wrap at 2**P keeps full/empty correct.
  - Simultaneous remote pointer move and local handshake: both are applied and each half uses only its own synced copy.
- Reset mid-operation: the local state clears; in-flight transactions are lost. Both ends must be reset together; system-level isolation is outside this block.
- Only gray pointers cross domains. Data words are sampled only when empty is false by synced pointer.

Decomposition:
- Package alsaqr_cdc_pkg:
  - bin2gray and gray2bin functions.
  - Per-channel width helper functions (AW = ADDR+3, W = DATA+DATA/8, B = 2, R = DATA+2).
- Sub-module alsaqr_gray_ptr_sync: SYNC_STAGES-deep gray pointer synchronizer with synchronous active-high reset. It is instantiated 5 times (one per channel).
- FIFO reader and writer logic is inline.

Test Plan:
- Reset: hold dst_rst_i for 3 cycles with random async inputs -> all pointers and data outputs are 0; valids, b_ready and r_ready are 0 throughout.
- Single write: source gives AW addr 0x1000_0040 prot 0, W data 0xDEADBEEF_CAFEF00D strb 0xFF, wptrs 0->1 -> master aw_valid and w_valid assert 2 cycles later. After the handshakes, aw_rptr_o and w_rptr_o = gray 1 = 2'b01.
- B return: a slave resp OKAY, then a second resp SLVERR with b_rptr_i stuck at 0 (LOG_DEPTH=1) -> two writes accepted and b_wptr_o = 2'b11 (gray 2), full, b_ready = 0. Set b_rptr_i = 2'b01 -> b_ready returns after 2 cycles.
- Wrap: 10 AR/R round trips with LOG_DEPTH=1 -> pointers cycle 00,01,11,10,00; R data 0x0..0x9 delivered in order with no loss or duplication.
- Backpressure: hold ar_ready = 0 for 5 cycles with an entry pending -> ar_valid stays 1 with a stable payload and ar_rptr_o is unchanged.
- Mid-operation reset: assert dst_rst_i one cycle after an R handshake -> r_wptr_o returns to 0 next edge and r_ready = 0 during reset.
